// File: rtl/mux_8to1.sv
// Registered 8-to-1 word multiplexer: O takes the input picked by S (A..H for S = 0..7).
// Latency: 1 cycle from a change on S or on the selected input to O.
// Backpressure: none. O reloads every cycle, and rst_n low clears it asynchronously.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; forces O to zero
//   A..H        WIDTH-bit data words, selected by S = 3'b000 .. 3'b111
//   S           3-bit select code; all eight codes are decoded
//   O           WIDTH-bit registered copy of the selected word
module mux_8to1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic [2:0]       S,
    output logic [WIDTH-1:0] O
);

    logic [WIDTH-1:0] o_d;
    logic [WIDTH-1:0] o_q;

    // Pure steering: a bit-for-bit copy of one input, with no arithmetic or inversion.
    // The zero default is reached only when S is X/Z in simulation.
    always_comb begin
        o_d = '0;
        case (S)
            3'b000:  o_d = A;
            3'b001:  o_d = B;
            3'b010:  o_d = C;
            3'b011:  o_d = D;
            3'b100:  o_d = E;
            3'b101:  o_d = F;
            3'b110:  o_d = G;
            3'b111:  o_d = H;
            default: o_d = '0;
        endcase
    end

    // The output flop keeps O glitch-free for downstream logic. It is the only state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else begin
            o_q <= o_d;
        end
    end

    assign O = o_q;

endmodule

// File: tb/tb_mux_8to1.sv
module tb_mux_8to1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, b, c, d, e, f, g, h;
    logic [2:0] s;
    logic [3:0] o;

    logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;
    logic [2:0] s8;
    logic [7:0] o8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_8to1 #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .A(a), .B(b), .C(c), .D(d), .E(e), .F(f), .G(g), .H(h),
        .S(s), .O(o)
    );

    mux_8to1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .A(a8), .B(b8), .C(c8), .D(d8), .E(e8), .F(f8), .G(g8), .H(h8),
        .S(s8), .O(o8)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
        e = 4'h5; f = 4'h6; g = 4'h7; h = 4'h9;
        s = 3'd0;
        a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
        e8 = 8'h55; f8 = 8'h66; g8 = 8'h77; h8 = 8'h88;
        s8 = 3'd0;
        #1;
        checks++;
        if (o !== 4'h0) begin
            errors++;
            $display("FAIL reset_initial: got %h expected %h", o, 4'h0);
        end
        checks++;
        if (o8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_initial_w8: got %h expected %h", o8, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o !== 4'h0) begin
                errors++;
                $display("FAIL reset_held_%0d: got %h expected %h", i, o, 4'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_before_edge: got %h expected %h", o, 4'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (o !== 4'h1) begin
            errors++;
            $display("FAIL reset_first_load: got %h expected %h", o, 4'h1);
        end
    endtask

    task automatic test_select_sweep();
        logic [3:0] exp_tbl [8];
        exp_tbl = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hD, 4'hF};
        @(negedge clk);
        a = 4'h8; b = 4'h9; c = 4'hA; d = 4'hB;
        e = 4'hC; f = 4'hE; g = 4'hD; h = 4'hF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s = 3'(i);
            @(posedge clk); #1;
            checks++;
            if (o !== exp_tbl[i]) begin
                errors++;
                $display("FAIL sweep_s%0d: got %h expected %h", i, o, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        s = 3'd0;
        @(posedge clk); #1;
        checks++;
        if (o !== 4'h8) begin
            errors++;
            $display("FAIL latency_setup: got %h expected %h", o, 4'h8);
        end
        @(negedge clk);
        d = 4'hB;
        s = 3'd3;
        #1;
        checks++;
        if (o !== 4'h8) begin
            errors++;
            $display("FAIL latency_hold_old: got %h expected %h", o, 4'h8);
        end
        @(posedge clk); #1;
        checks++;
        if (o !== 4'hB) begin
            errors++;
            $display("FAIL latency_new: got %h expected %h", o, 4'hB);
        end
    endtask

    task automatic test_isolation();
        @(negedge clk);
        s = 3'd2;
        c = 4'hA;
        a = 4'h0; b = 4'h0; d = 4'h0; e = 4'h0; f = 4'h0; g = 4'h0; h = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o !== 4'hA) begin
                errors++;
                $display("FAIL isolation_%0d: got %h expected %h", i, o, 4'hA);
            end
            @(negedge clk);
            a = ~a; b = ~b; d = ~d; e = ~e; f = ~f; g = ~g; h = ~h;
        end
        // Change select and the newly selected data before the same edge.
        s = 3'd5;
        f = 4'h3;
        @(posedge clk); #1;
        checks++;
        if (o !== 4'h3) begin
            errors++;
            $display("FAIL simultaneous_change: got %h expected %h", o, 4'h3);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        s = 3'd7;
        h = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (o !== 4'hF) begin
            errors++;
            $display("FAIL async_setup: got %h expected %h", o, 4'hF);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o !== 4'h0) begin
            errors++;
            $display("FAIL async_clear_no_edge: got %h expected %h", o, 4'h0);
        end
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (o !== 4'h0) begin
            errors++;
            $display("FAIL async_release_before_edge: got %h expected %h", o, 4'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (o !== 4'hF) begin
            errors++;
            $display("FAIL async_reload: got %h expected %h", o, 4'hF);
        end
    endtask

    task automatic test_width8();
        @(negedge clk);
        s8 = 3'd4;
        e8 = 8'hA5;
        @(posedge clk); #1;
        checks++;
        if (o8 !== 8'hA5) begin
            errors++;
            $display("FAIL width8_select_e: got %h expected %h", o8, 8'hA5);
        end
        @(negedge clk);
        s8 = 3'd6;
        g8 = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if (o8 !== 8'h3C) begin
            errors++;
            $display("FAIL width8_select_g: got %h expected %h", o8, 8'h3C);
        end
    endtask

    initial begin
        test_reset();
        test_select_sweep();
        test_latency();
        test_isolation();
        test_async_reset();
        test_width8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
